// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial WIDTH-bit adder with valid/ready handshakes
// Optional subtract mode (sub port, a-b as a+~b+1) enabled by SERIAL_ADD_SUB_EN.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_shift;
    logic             cout_r;
    logic             carry;
    logic [CNT_W-1:0] bit_cnt;
    logic             last_bit;

    logic             init_carry;
    logic [WIDTH-1:0] b_load;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction reuses the adder: invert b and seed the carry with 1.
    assign init_carry = sub;
    assign b_load     = sub ? ~b : b;
`else
    assign init_carry = 1'b0;
    assign b_load     = b;
`endif

    logic ha0_s, ha0_c, fa_s, ha1_c, fa_c;

    half_adder u_ha0 (.x(a_sr[0]), .y(b_sr[0]), .s(ha0_s), .c(ha0_c));
    half_adder u_ha1 (.x(ha0_s),   .y(carry),   .s(fa_s),  .c(ha1_c));
    assign fa_c = ha0_c | ha1_c;

    // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at sum[0].
    always_comb begin
        sum_shift            = sum_r >> 1;
        sum_shift[WIDTH-1]   = fa_s;
    end

    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            carry   <= 1'b0;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sr    <= a;
                        b_sr    <= b_load;
                        carry   <= init_carry;
                        bit_cnt <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    sum_r   <= sum_shift;
                    carry   <= fa_c;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (last_bit) begin
                        cout_r <= fa_c;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign sum       = sum_r;
    assign cout      = cout_r;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl (WIDTH=8)

module tb_serial_add_ctrl;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    logic       sub;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("sb_sum", {24'd0, sum}, {24'd0, e[8:1]});
                chk("sb_cout", {31'd0, cout}, {31'd0, e[0]});
            end
        end
    end

    task automatic wait_ready();
        int i;
        for (i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (in_ready) break;
        end
        if (i == 50) chk("wait_in_ready_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        if (i == 50) chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    // Drive one operand pair and hold it until the accept edge.
    task automatic accept(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                          input logic push, input logic [7:0] esum, input logic ecout);
        wait_ready();
        a = av; b = bv; sub = sv; in_valid = 1'b1;
        @(posedge clk);
        if (push) exp_q.push_back({esum, ecout});
        #1;
        in_valid = 1'b0;
        a = 8'h00; b = 8'h00; sub = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sum", {24'd0, sum}, 32'h0);
        chk("rst_cout", {31'd0, cout}, 32'h0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'h1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // FF+01: exact latency of 8 edges after accept
        accept(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            chk($sformatf("latency_ov_%0d", i), {31'd0, out_valid}, {31'd0, (i == 8)});
        end
        wait_idle();

        // A5+5A with ignored in_valid traffic during RUN
        accept(8'hA5, 8'h5A, 1'b0, 1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0]; a = 8'h11; b = 8'h22;
            @(negedge clk);
            chk("run_in_ready", {31'd0, in_ready}, 32'h0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_idle();

        // Backpressure: 37+11 held while out_ready=0
        out_ready = 1'b0;
        accept(8'h37, 8'h11, 1'b0, 1'b1, 8'h48, 1'b0);
        begin
            int i;
            for (i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (out_valid) break;
            end
            if (i == 20) chk("wait_out_valid_timeout", 32'd1, 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {31'd0, out_valid}, 32'h1);
            chk("bp_sum", {24'd0, sum}, 32'h48);
            chk("bp_cout", {31'd0, cout}, 32'h0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_in_ready", {31'd0, in_ready}, 32'h1);
        chk("bp_idle_out_valid", {31'd0, out_valid}, 32'h0);
        chk("bp_sum_kept", {24'd0, sum}, 32'h48);

        // Reset three cycles into RUN; result discarded
        accept(8'h03, 8'h04, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'h1);
        chk("mid_rst_busy", {31'd0, busy}, 32'h0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'h0);
        chk("mid_rst_sum", {24'd0, sum}, 32'h0);
        chk("mid_rst_cout", {31'd0, cout}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        accept(8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0);
        wait_idle();

        // Wrap with carry out
        accept(8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1);
        wait_idle();
        accept(8'h0F, 8'h01, 1'b0, 1'b1, 8'h10, 1'b0);
        wait_idle();

`ifdef SERIAL_ADD_SUB_EN
        accept(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0);
        wait_idle();
        accept(8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1);
        wait_idle();
`endif

        repeat (2) @(posedge clk);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
